// File: rtl/mul16_seq_112.sv
// Sequential unsigned 16x16->32 shift-and-add multiplier with start/busy/done handshake.
// Contains the 16-bit two-level carry-lookahead adder used as its partial-sum stage.

module cla16_112 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c0,
  output logic [15:0] s,
  output logic        gx,
  output logic        px
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, pg, gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end

    gc[0] = c0;
    gc[1] = gg[0] | (pg[0] & c0);
    gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c0);
    gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c0);

    // Bit carries inside each nibble derive from that nibble's lookahead carry-in.
    c = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int unsigned j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end

    s  = p ^ c;
    gx = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0]);
    px = &pg;
  end
endmodule

module mul16_seq_112 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] m_q, m_d;
  logic [31:0] p_q, p_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] product_q, product_d;

  logic [15:0] cla_b, cla_s;
  logic        cla_gx, px_unused;

  // Carry-in is tied low, so group generate alone is the carry-out.
  assign cla_b = p_q[0] ? m_q : '0;

  cla16_112 u_cla (
    .a  (p_q[31:16]),
    .b  (cla_b),
    .c0 (1'b0),
    .s  (cla_s),
    .gx (cla_gx),
    .px (px_unused)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          p_d     = {16'h0000, b};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d   = {cla_gx, cla_s, p_q[15:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          product_d = p_d;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
endmodule

// File: tb/tb_mul16_seq_112.sv
// Scoreboard bench for mul16_seq_112: a cycle-accounting model predicts accepts,
// busy/done timing and the held product; a negedge monitor compares every cycle.

module tb_mul16_seq_112;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      last_acc = -100;
  logic [31:0] exp_q[$];
  logic [31:0] held = '0;

  mul16_seq_112 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a start is taken when the unit has been free for 18 edges; result is a*b.
  always @(posedge clk) begin
    cyc++;
    if (!rst && start && (cyc - last_acc >= 18)) begin
      last_acc = cyc;
      exp_q.push_back(32'(a) * 32'(b));
    end
  end

  always @(posedge rst) begin
    exp_q.delete();
    last_acc = -100;
    held = '0;
  end

  always @(negedge clk) begin
    longint d;
    logic   exp_busy, exp_done;
    d        = cyc - last_acc;
    exp_busy = !rst && (d >= 0) && (d < 16);
    exp_done = !rst && (d == 16);
    chk("busy", {31'b0, busy}, {31'b0, exp_busy});
    chk("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: done expected with empty queue (edge %0d)", cyc);
      end else begin
        held = exp_q.pop_front();
      end
    end
    chk("product", product, held);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic mul(input logic [15:0] x, input logic [15:0] y);
    start = 1'b1;
    a = x;
    b = y;
    tick(1);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  function automatic logic [15:0] rand_op();
    logic [3:0] sel;
    sel = 4'($urandom_range(0, 15));
    if (sel == 4'd0) return 16'h0000;
    if (sel == 4'd1) return 16'hFFFF;
    if (sel == 4'd2) return 16'h0001;
    return 16'($urandom);
  endfunction

  initial begin
    start = 1'b0;
    a = '0;
    b = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);

    mul(16'h0003, 16'h0005); tick(18);
    mul(16'hFFFF, 16'hFFFF); tick(18);
    mul(16'h1234, 16'h0000); tick(18);
    mul(16'h0001, 16'hABCD); tick(25);

    // Starts during RUN and in the DONE cycle must be ignored.
    mul(16'h0003, 16'h0005);
    tick(3);
    start = 1'b1; a = 16'h0007; b = 16'h0009;
    tick(1);
    start = 1'b0;
    tick(5);
    start = 1'b1; a = 16'hFFFF; b = 16'h1111;
    tick(2);
    start = 1'b0;
    tick(5);
    start = 1'b1; a = 16'h2222; b = 16'h3333;
    tick(1);
    start = 1'b0;
    tick(5);

    // Held start re-triggers every 18 edges.
    start = 1'b1; a = 16'($urandom); b = 16'($urandom);
    tick(40);
    start = 1'b0;
    tick(20);

    // Reset after 7 RUN cycles aborts the operation.
    mul(16'h8000, 16'h8000);
    tick(7);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    mul(16'h00FF, 16'h0100);
    tick(20);

    for (int i = 0; i < 1000; i++) begin
      mul(rand_op(), rand_op());
      tick(17 + int'($urandom_range(0, 3)));
    end

    tick(25);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
